// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam int MIN_DIV = 2;

   function automatic logic div_legal(input int unsigned div);
      return div >= MIN_DIV;
   endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter: produces the registered clkout/tick pair and flags the
// wrap edge of each period for the controller.
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] cur_div,
   input  logic         start,
   input  logic         stop,
   output logic         clkout,
   output logic         tick,
   output logic         wrap
);

   logic         r_run;
   logic [W-1:0] r_cnt;
   logic         r_clkout;
   logic         r_tick;

   logic [W-1:0] w_half;
   logic [W-1:0] w_last;
   logic [W:0]   w_next;
   logic         w_next_hi;

   assign w_half    = cur_div >> 1;
   assign w_last    = cur_div - {{(W-1){1'b0}}, 1'b1};
   assign w_next    = {1'b0, r_cnt} + {{W{1'b0}}, 1'b1};
   assign w_next_hi = w_next < {1'b0, w_half};
   assign wrap      = r_run && (r_cnt == w_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_run    <= 1'b0;
         r_cnt    <= '0;
         r_clkout <= 1'b0;
         r_tick   <= 1'b0;
      end else if (!r_run) begin
         r_cnt <= '0;
         if (start) begin
            r_run    <= 1'b1;
            r_clkout <= 1'b1;
            r_tick   <= 1'b1;
         end else begin
            r_clkout <= 1'b0;
            r_tick   <= 1'b0;
         end
      end else if (wrap) begin
         r_cnt <= '0;
         if (stop) begin
            r_run    <= 1'b0;
            r_clkout <= 1'b0;
            r_tick   <= 1'b0;
         end else begin
            r_clkout <= 1'b1;
            r_tick   <= 1'b1;
         end
      end else begin
         r_cnt    <= w_next[W-1:0];
         r_clkout <= w_next_hi;
         r_tick   <= 1'b0;
      end
   end

   assign clkout = r_clkout;
   assign tick   = r_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: ratio handshake, pending-ratio FSM and run/stop
// sequencing around clk_div_core.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int W           = 8,
   parameter int DEFAULT_DIV = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_div,
   output logic         clkout,
   output logic         tick,
   output logic         busy,
   output logic         err
);

   localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);

   state_t       r_state;
   logic [W-1:0] r_cur_div;
   logic [W-1:0] r_pend_div;
   logic         r_err;

   logic w_xfer;
   logic w_legal;
   logic w_start;
   logic w_wrap;

   assign cfg_ready = (r_state != PEND);
   assign busy      = (r_state != IDLE);
   assign err       = r_err;

   assign w_xfer  = cfg_valid && cfg_ready;
   assign w_legal = div_legal(32'(cfg_div));
   assign w_start = (r_state == IDLE) && en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cur_div  <= DEF_DIV;
         r_pend_div <= DEF_DIV;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_xfer && !w_legal;
         unique case (r_state)
            IDLE: begin
               if (w_xfer && w_legal)
                  r_cur_div <= cfg_div;
               if (en)
                  r_state <= RUN;
            end
            RUN: begin
               // A ratio arriving on the wrap edge still waits a full period
               if (w_wrap && !en) begin
                  r_state <= IDLE;
                  if (w_xfer && w_legal)
                     r_cur_div <= cfg_div;
               end else if (w_xfer && w_legal) begin
                  r_pend_div <= cfg_div;
                  r_state    <= PEND;
               end
            end
            PEND: begin
               if (w_wrap) begin
                  r_cur_div <= r_pend_div;
                  r_state   <= en ? RUN : IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   clk_div_core #(
      .W (W)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .cur_div (r_cur_div),
      .start   (w_start),
      .stop    (!en),
      .clkout  (clkout),
      .tick    (tick),
      .wrap    (w_wrap)
   );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: period/phase scoreboard plus
// hand-written handshake, stop and reset sequences.
module tb_clk_div_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_div;
   logic       clkout;
   logic       tick;
   logic       busy;
   logic       err;

   int errs   = 0;
   int checks = 0;

   typedef struct {
      int   div;
      logic same;
      int   per;
      int   hi;
   } vec_t;

   typedef struct {
      string name;
      int    per;
      int    hi;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[6];

   always #5 clk = ~clk;

   clk_div_ctrl #(
      .W           (8),
      .DEFAULT_DIV (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_div   (cfg_div),
      .clkout    (clkout),
      .tick      (tick),
      .busy      (busy),
      .err       (err)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input string nm, input int per, input int hi);
      exp_t e;
      e.name = nm;
      e.per  = per;
      e.hi   = hi;
      sb.push_back(e);
   endtask

   // Starts on a negedge showing tick=1; ends on the next such negedge.
   task automatic measure(input int inj_at, input logic [7:0] inj_div,
                          output int per, output int hi,
                          output int nrdy, output int nerr);
      per  = 0;
      hi   = 0;
      nrdy = 0;
      nerr = 0;
      do begin
         if (clkout) hi++;
         if (per == inj_at) begin
            cfg_valid = 1'b1;
            cfg_div   = inj_div;
         end else begin
            cfg_valid = 1'b0;
         end
         per++;
         @(negedge clk);
         if (!cfg_ready) nrdy++;
         if (err) nerr++;
      end while (!tick && per < 600);
      cfg_valid = 1'b0;
   endtask

   task automatic pop_cmp(input int per, input int hi);
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
         return;
      end
      e = sb.pop_front();
      chk({e.name, "_period"}, per, e.per);
      chk({e.name, "_high"}, hi, e.hi);
   endtask

   task automatic run_period(input int inj_at, input logic [7:0] inj_div,
                             output int nrdy, output int nerr);
      int per;
      int hi;
      measure(inj_at, inj_div, per, hi, nrdy, nerr);
      pop_cmp(per, hi);
   endtask

   task automatic stop_run(input string nm);
      en = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk({nm, "_stopped"}, busy, 0);
   endtask

   initial begin
      int nrdy;
      int nerr;
      int k;
      int hi;

      vecs[0] = '{div: 5,   same: 1'b0, per: 5,   hi: 2};
      vecs[1] = '{div: 2,   same: 1'b0, per: 2,   hi: 1};
      vecs[2] = '{div: 3,   same: 1'b1, per: 3,   hi: 1};
      vecs[3] = '{div: 7,   same: 1'b0, per: 7,   hi: 3};
      vecs[4] = '{div: 255, same: 1'b0, per: 255, hi: 127};
      vecs[5] = '{div: 9,   same: 1'b1, per: 9,   hi: 4};

      reset     = 1'b1;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = 8'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_clkout", clkout, 0);
      chk("rst_tick", tick, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_cfg_ready", cfg_ready, 1);

      en = 1'b1;
      @(negedge clk);
      chk("dflt_start_tick", tick, 1);
      chk("dflt_start_clkout", clkout, 1);
      push("dflt_p1", 16, 8);
      push("dflt_p2", 16, 8);
      run_period(-1, 8'd0, nrdy, nerr);
      run_period(-1, 8'd0, nrdy, nerr);
      stop_run("dflt");

      foreach (vecs[i]) begin
         if (!vecs[i].same) begin
            cfg_valid = 1'b1;
            cfg_div   = vecs[i].div[7:0];
            @(negedge clk);
            cfg_valid = 1'b0;
            chk($sformatf("v%0d_idle_busy", i), busy, 0);
         end
         en = 1'b1;
         if (vecs[i].same) begin
            cfg_valid = 1'b1;
            cfg_div   = vecs[i].div[7:0];
         end
         @(negedge clk);
         cfg_valid = 1'b0;
         chk($sformatf("v%0d_start_tick", i), tick, 1);
         push($sformatf("v%0d_p1", i), vecs[i].per, vecs[i].hi);
         push($sformatf("v%0d_p2", i), vecs[i].per, vecs[i].hi);
         run_period(-1, 8'd0, nrdy, nerr);
         run_period(-1, 8'd0, nrdy, nerr);
         chk($sformatf("v%0d_busy", i), busy, 1);
         stop_run($sformatf("v%0d", i));
      end

      cfg_valid = 1'b1;
      cfg_div   = 8'd5;
      @(negedge clk);
      cfg_valid = 1'b0;
      en = 1'b1;
      @(negedge clk);
      chk("ill_start_tick", tick, 1);
      push("ill_p1", 5, 2);
      run_period(1, 8'd1, nrdy, nerr);
      chk("ill_err_pulses", nerr, 1);
      chk("ill_ready_low", nrdy, 0);
      push("ill_p2", 5, 2);
      run_period(-1, 8'd0, nrdy, nerr);

      push("chg_p5", 5, 2);
      run_period(0, 8'd6, nrdy, nerr);
      push("chg_p6", 6, 3);
      run_period(2, 8'd4, nrdy, nerr);
      chk("chg_ready_low", nrdy, 3);
      chk("chg_ready_back", cfg_ready, 1);
      push("chg_p4a", 4, 2);
      run_period(-1, 8'd0, nrdy, nerr);
      push("wrap_p4a", 4, 2);
      run_period(3, 8'd3, nrdy, nerr);
      push("wrap_p4b", 4, 2);
      run_period(-1, 8'd0, nrdy, nerr);
      push("wrap_p3", 3, 1);
      run_period(-1, 8'd0, nrdy, nerr);

      cfg_valid = 1'b1;
      cfg_div   = 8'd10;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("mrst_pending", cfg_ready, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mrst_clkout", clkout, 0);
      chk("mrst_tick", tick, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_err", err, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("mrst_start_tick", tick, 1);
      push("mrst_p16", 16, 8);
      run_period(0, 8'd8, nrdy, nerr);

      repeat (3) @(negedge clk);
      en = 1'b0;
      k  = 0;
      hi = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy) break;
         k++;
         if (clkout) hi++;
      end
      chk("stop_tail_cycles", k, 4);
      chk("stop_tail_high", hi, 0);
      chk("stop_clkout", clkout, 0);
      k = 0;
      repeat (20) begin
         @(negedge clk);
         if (tick) k++;
      end
      chk("stop_no_tick", k, 0);
      chk("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
